dmem_resp_ctrl: RTL and testbench

//  Memory-side responder for processor load/store requests. Accepts one request at a

---
 rtl/dmem_pkg.sv | 50 +++++
 rtl/dmem_sram.sv | 27 ++
 rtl/dmem_resp_ctrl.sv | 153 +++++++++++++++
 tb/tb_dmem_resp_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: funct3 codes, FSM states,
// and the access-size decode also used by the processor's load/store path.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StMrg,
    StWr,
    StRsp
  } dmem_state_t;

  typedef enum logic [1:0] {
    SzByte,
    SzHalf,
    SzWord,
    SzBad
  } dmem_size_t;

  // Unsigned load variants have no store counterpart, so they decode as illegal for stores.
  function automatic dmem_size_t dmem_size(input logic we, input logic [2:0] funct3);
    dmem_size_t sz;
    case (funct3)
      F3_B:    sz = SzByte;
      F3_H:    sz = SzHalf;
      F3_W:    sz = SzWord;
      F3_BU:   sz = we ? SzBad : SzByte;
      F3_HU:   sz = we ? SzBad : SzHalf;
      default: sz = SzBad;
    endcase
    return sz;
  endfunction

  function automatic logic dmem_misaligned(input dmem_size_t sz, input logic [1:0] off);
    logic mis;
    case (sz)
      SzHalf:  mis = off[0];
      SzWord:  mis = |off;
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/dmem_sram.sv
// Single-port synchronous-read SRAM: read data is valid the cycle after en.
// The array has no reset so contents survive a controller reset.
module dmem_sram #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/dmem_resp_ctrl.sv
// Load/store responder: one request at a time, decodes size/alignment/range, and
// runs the SRAM access (read-modify-write for sub-word stores) before responding.
module dmem_resp_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  dmem_state_t state_q, state_d;
  logic        we_q;
  dmem_size_t  size_q;
  logic [1:0]  off_q;
  logic [AW-1:0] idx_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        accept;
  dmem_size_t  req_size;
  logic        req_err;
  logic        req_oor;

  logic          sram_en;
  logic          sram_we;
  logic [31:0]   sram_rdata;
  logic [31:0]   load_word;
  logic [31:0]   merge_word;

  assign req_ready = (state_q == StIdle);
  assign accept    = req_valid & req_ready;
  assign req_size  = dmem_size(req_we, req_funct3);
  assign req_oor   = ({2'b00, req_addr[31:2]} >= DEPTH);
  assign req_err   = (req_size == SzBad) | dmem_misaligned(req_size, req_addr[1:0]) | req_oor;

  assign rsp_valid = (state_q == StRsp);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  assign sram_en = (state_q == StRd) | (state_q == StWr);
  assign sram_we = (state_q == StWr);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (req_err) begin
            state_d = StRsp;
          end else if (req_we && (req_size == SzWord)) begin
            state_d = StWr;
          end else begin
            state_d = StRd;
          end
        end
      end
      StRd:    state_d = StMrg;
      StMrg:   state_d = we_q ? StWr : StRsp;
      StWr:    state_d = StRsp;
      StRsp:   state_d = rsp_ready ? StIdle : StRsp;
      default: state_d = StIdle;
    endcase
  end

  // Lane extraction for loads: data lands at bit 0, upper bits always zero.
  always_comb begin
    load_word = 32'h0;
    case (size_q)
      SzByte:  load_word = (sram_rdata >> {off_q, 3'b000}) & 32'h0000_00ff;
      SzHalf:  load_word = (sram_rdata >> {off_q[1], 4'b0000}) & 32'h0000_ffff;
      default: load_word = sram_rdata;
    endcase
  end

  always_comb begin
    logic [31:0] mask;
    logic [31:0] ins;
    mask = 32'h0;
    ins  = 32'h0;
    case (size_q)
      SzByte: begin
        mask = 32'h0000_00ff << {off_q, 3'b000};
        ins  = {24'h0, wdata_q[7:0]} << {off_q, 3'b000};
      end
      SzHalf: begin
        mask = 32'h0000_ffff << {off_q[1], 4'b0000};
        ins  = {16'h0, wdata_q[15:0]} << {off_q[1], 4'b0000};
      end
      default: begin
        mask = 32'hffff_ffff;
        ins  = wdata_q;
      end
    endcase
    merge_word = (sram_rdata & ~mask) | ins;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      we_q    <= 1'b0;
      size_q  <= SzByte;
      off_q   <= 2'b00;
      idx_q   <= '0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q    <= req_we;
        size_q  <= req_size;
        off_q   <= req_addr[1:0];
        idx_q   <= req_addr[AW+1:2];
        wdata_q <= req_wdata;
        rdata_q <= 32'h0;
        err_q   <= req_err;
      end else if (state_q == StMrg) begin
        // Stores reuse wdata_q to hold the merged word written in StWr.
        if (we_q) begin
          wdata_q <= merge_word;
        end else begin
          rdata_q <= load_word;
        end
      end
    end
  end

  dmem_sram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_sram (
    .clk   (clk),
    .en    (sram_en),
    .we    (sram_we),
    .addr  (idx_q),
    .wdata (wdata_q),
    .rdata (sram_rdata)
  );

endmodule

// File: tb/tb_dmem_resp_ctrl.sv
// Scoreboard bench for dmem_resp_ctrl: expectations are queued as requests are
// issued and popped when the response appears.
module tb_dmem_resp_ctrl;
  import dmem_pkg::*;

  localparam int unsigned DEPTH = 1024;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  dmem_resp_ctrl #(
    .DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one request and wait for the accepting edge; inputs are scrambled afterwards.
  task automatic send(input string tag, input logic we, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] wdata);
    int w = 0;
    while (!req_ready && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    if (!req_ready) check_eq({tag, "_ready_timeout"}, 32'(req_ready), 32'd1);
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    req_valid  = 1'b1;
    @(posedge clk); #1;
    req_valid  = 1'b0;
    req_addr   = $urandom;
    req_wdata  = $urandom;
    req_funct3 = 3'($urandom_range(0, 7));
    req_we     = ~we;
  endtask

  task automatic collect(input string tag, input int hold);
    int   lat = 1;
    exp_t e;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    if (exp_q.size() == 0) begin
      check_eq({tag, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = exp_q.pop_front();
    if (!rsp_valid) begin
      check_eq({tag, "_rsp_timeout"}, 32'(rsp_valid), 32'd1);
      return;
    end
    check_eq({tag, "_rdata"}, rsp_rdata, e.rdata);
    check_eq({tag, "_err"}, 32'(rsp_err), 32'(e.err));
    check_eq({tag, "_lat"}, 32'(lat), 32'(e.lat));
    if (hold > 0) begin
      rsp_ready = 1'b0;
      // A competing store is presented while blocked; it must be ignored.
      req_we     = 1'b1;
      req_funct3 = F3_W;
      req_addr   = 32'h10;
      req_wdata  = 32'h0bad_f00d;
      req_valid  = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        check_eq({tag, "_hold_valid"}, 32'(rsp_valid), 32'd1);
        check_eq({tag, "_hold_rdata"}, rsp_rdata, e.rdata);
        check_eq({tag, "_hold_ready"}, 32'(req_ready), 32'd0);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
    end
    @(posedge clk); #1;
    check_eq({tag, "_done"}, 32'(rsp_valid), 32'd0);
  endtask

  task automatic xact(input string tag, input logic we, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
    exp_t e;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    e.lat   = exp_lat;
    exp_q.push_back(e);
    send(tag, we, f3, addr, wdata);
    collect(tag, 0);
  endtask

  initial begin
    exp_t e;
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    rsp_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check_eq("rst_req_ready", 32'(req_ready), 32'd1);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_rsp_rdata", rsp_rdata, 32'h0);
    check_eq("rst_rsp_err", 32'(rsp_err), 32'd0);

    xact("sw10", 1'b1, F3_W, 32'h10, 32'hdead_beef, 32'h0, 1'b0, 2);
    xact("lw10", 1'b0, F3_W, 32'h10, 32'h0, 32'hdead_beef, 1'b0, 3);

    xact("sw20",  1'b1, F3_W,  32'h20, 32'h1122_3344, 32'h0, 1'b0, 2);
    xact("sb21",  1'b1, F3_B,  32'h21, 32'hffff_ffaa, 32'h0, 1'b0, 4);
    xact("lw20",  1'b0, F3_W,  32'h20, 32'h0, 32'h1122_aa44, 1'b0, 3);
    xact("lbu23", 1'b0, F3_BU, 32'h23, 32'h0, 32'h0000_0011, 1'b0, 3);
    xact("lh22",  1'b0, F3_H,  32'h22, 32'h0, 32'h0000_1122, 1'b0, 3);
    xact("lb21",  1'b0, F3_B,  32'h21, 32'h0, 32'h0000_00aa, 1'b0, 3);
    xact("lhu20", 1'b0, F3_HU, 32'h20, 32'h0, 32'h0000_aa44, 1'b0, 3);

    xact("sw24", 1'b1, F3_W, 32'h24, 32'h0, 32'h0, 1'b0, 2);
    xact("sh26", 1'b1, F3_H, 32'h26, 32'h1234_beef, 32'h0, 1'b0, 4);
    xact("lw24", 1'b0, F3_W, 32'h24, 32'h0, 32'hbeef_0000, 1'b0, 3);

    xact("sw00",    1'b1, F3_W,   32'h00, 32'h0102_0304, 32'h0, 1'b0, 2);
    xact("lw02",    1'b0, F3_W,   32'h02, 32'h0, 32'h0, 1'b1, 1);
    xact("lh03",    1'b0, F3_H,   32'h03, 32'h0, 32'h0, 1'b1, 1);
    xact("ld011",   1'b0, 3'b011, 32'h00, 32'h0, 32'h0, 1'b1, 1);
    xact("sw02",    1'b1, F3_W,   32'h02, 32'hffff_ffff, 32'h0, 1'b1, 1);
    xact("st100",   1'b1, F3_BU,  32'h00, 32'hffff_ffff, 32'h0, 1'b1, 1);
    xact("lw_oor",  1'b0, F3_W,   DEPTH * 4, 32'h0, 32'h0, 1'b1, 1);
    xact("sw_oor",  1'b1, F3_W,   DEPTH * 4, 32'hcafe_cafe, 32'h0, 1'b1, 1);
    xact("lw00",    1'b0, F3_W,   32'h00, 32'h0, 32'h0102_0304, 1'b0, 3);
    xact("sw_top",  1'b1, F3_W,   DEPTH * 4 - 4, 32'h7777_8888, 32'h0, 1'b0, 2);
    xact("lw_top",  1'b0, F3_W,   DEPTH * 4 - 4, 32'h0, 32'h7777_8888, 1'b0, 3);

    e.rdata = 32'hdead_beef;
    e.err   = 1'b0;
    e.lat   = 3;
    exp_q.push_back(e);
    send("hold", 1'b0, F3_W, 32'h10, 32'h0);
    collect("hold", 5);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_eq("hold_no_extra_rsp", 32'(rsp_valid), 32'd0);
    end
    xact("lw10_after_hold", 1'b0, F3_W, 32'h10, 32'h0, 32'hdead_beef, 1'b0, 3);

    xact("sw30", 1'b1, F3_W, 32'h30, 32'h5566_7788, 32'h0, 1'b0, 2);
    send("sb30", 1'b1, F3_B, 32'h30, 32'h0000_00aa);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check_eq("rst_mid_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_mid_err", 32'(rsp_err), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check_eq("rst_mid_ready", 32'(req_ready), 32'd1);
    xact("lw30", 1'b0, F3_W, 32'h30, 32'h0, 32'h5566_7788, 1'b0, 3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
